// File: rtl/ping_sequencer.sv
// Ultrasonic ping sequencer: per beam angle fire a burst, blank ring-down, listen, report, gap.
// Optional define PING_SEQ_ECHO_SYNC_EN adds a 2-flop synchronizer on echo_in.
module ping_sequencer #(
  parameter int unsigned BURST_CYCLES    = 20000,
  parameter int unsigned BLANK_CYCLES    = 60000,
  parameter int unsigned MAX_TIME_WINDOW = 500000,
  parameter int unsigned GAP_CYCLES      = 100000,
  parameter int unsigned NUM_ANGLES      = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          start_in,
  input  logic                          stop_in,
  input  logic                          continuous_in,
  input  logic                          echo_in,
  output logic                          burst_active_out,
  output logic [$clog2(NUM_ANGLES)-1:0] angle_idx_out,
  output logic [31:0]                   time_since_emission_out,
  output logic                          listen_out,
  output logic [31:0]                   echo_time_out,
  output logic                          echo_valid_out,
  output logic                          timeout_out,
  output logic [$clog2(NUM_ANGLES)-1:0] angle_result_out,
  output logic                          scan_done_out,
  output logic                          busy_out
);

  localparam int AW = $clog2(NUM_ANGLES);

  localparam logic [31:0] BurstLast = 32'(BURST_CYCLES - 1);
  localparam logic [31:0] BlankLast = 32'(BLANK_CYCLES - 1);
  localparam logic [31:0] WinLast   = 32'(MAX_TIME_WINDOW - 1);
  localparam logic [31:0] GapLast   = 32'(GAP_CYCLES - 1);
  localparam logic [AW-1:0] AngleLast = AW'(NUM_ANGLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFire,
    StBlank,
    StListen,
    StRecord,
    StGap
  } state_e;

  state_e        r_state, w_state_nxt;
  logic [31:0]   r_cnt, w_cnt_nxt;
  logic [31:0]   r_gap_cnt, w_gap_nxt;
  logic [AW-1:0] r_angle, w_angle_nxt;
  logic          r_stop_pend, w_stop_nxt;
  logic [31:0]   r_echo_time, w_echo_time_nxt;
  logic          r_echo_valid, w_echo_valid_nxt;
  logic          r_timeout, w_timeout_nxt;
  logic [AW-1:0] r_angle_result, w_angle_result_nxt;
  logic          r_scan_done, w_scan_done_nxt;
  logic          r_burst, r_listen, r_busy;

  logic          w_echo;
  logic [31:0]   w_capture;
  logic          w_stop_eff;

`ifdef PING_SEQ_ECHO_SYNC_EN
  logic [1:0] r_echo_sync;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_echo_sync <= 2'b00;
    end else begin
      r_echo_sync <= {r_echo_sync[0], echo_in};
    end
  end

  // Report the cycle echo_in was actually sampled, two cycles before qualification.
  assign w_echo    = r_echo_sync[1];
  assign w_capture = r_cnt - 32'd2;
`else
  assign w_echo    = echo_in;
  assign w_capture = r_cnt;
`endif

  assign w_stop_eff = r_stop_pend | stop_in;

  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_gap_nxt          = r_gap_cnt;
    w_angle_nxt        = r_angle;
    w_stop_nxt         = r_stop_pend | (stop_in & (r_state != StIdle));
    w_echo_time_nxt    = r_echo_time;
    w_echo_valid_nxt   = 1'b0;
    w_timeout_nxt      = 1'b0;
    w_angle_result_nxt = r_angle_result;
    w_scan_done_nxt    = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (start_in) begin
          w_state_nxt = StFire;
          w_cnt_nxt   = '0;
          w_angle_nxt = '0;
        end
      end
      StFire: begin
        w_cnt_nxt = r_cnt + 32'd1;
        // Equal burst and blank lengths skip the blanking state entirely.
        if (r_cnt == BlankLast) begin
          w_state_nxt = StListen;
        end else if (r_cnt == BurstLast) begin
          w_state_nxt = StBlank;
        end
      end
      StBlank: begin
        w_cnt_nxt = r_cnt + 32'd1;
        if (r_cnt == BlankLast) begin
          w_state_nxt = StListen;
        end
      end
      StListen: begin
        w_cnt_nxt = r_cnt + 32'd1;
        if (w_echo) begin
          w_state_nxt        = StRecord;
          w_echo_time_nxt    = w_capture;
          w_echo_valid_nxt   = 1'b1;
          w_angle_result_nxt = r_angle;
        end else if (r_cnt == WinLast) begin
          w_state_nxt        = StRecord;
          w_timeout_nxt      = 1'b1;
          w_angle_result_nxt = r_angle;
        end
      end
      StRecord: begin
        w_state_nxt = StGap;
        w_gap_nxt   = '0;
      end
      StGap: begin
        if (r_gap_cnt == GapLast) begin
          if (w_stop_eff) begin
            w_state_nxt = StIdle;
          end else if (r_angle != AngleLast) begin
            w_state_nxt = StFire;
            w_angle_nxt = r_angle + AW'(1);
            w_cnt_nxt   = '0;
          end else begin
            w_scan_done_nxt = 1'b1;
            if (continuous_in) begin
              w_state_nxt = StFire;
              w_angle_nxt = '0;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = StIdle;
            end
          end
        end else begin
          w_gap_nxt = r_gap_cnt + 32'd1;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase

    if (w_state_nxt == StIdle) begin
      w_stop_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state        <= StIdle;
      r_cnt          <= '0;
      r_gap_cnt      <= '0;
      r_angle        <= '0;
      r_stop_pend    <= 1'b0;
      r_echo_time    <= '0;
      r_echo_valid   <= 1'b0;
      r_timeout      <= 1'b0;
      r_angle_result <= '0;
      r_scan_done    <= 1'b0;
      r_burst        <= 1'b0;
      r_listen       <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_gap_cnt      <= w_gap_nxt;
      r_angle        <= w_angle_nxt;
      r_stop_pend    <= w_stop_nxt;
      r_echo_time    <= w_echo_time_nxt;
      r_echo_valid   <= w_echo_valid_nxt;
      r_timeout      <= w_timeout_nxt;
      r_angle_result <= w_angle_result_nxt;
      r_scan_done    <= w_scan_done_nxt;
      // Status flags decoded from the next state so they are flop outputs.
      r_burst        <= (w_state_nxt == StFire);
      r_listen       <= (w_state_nxt == StListen);
      r_busy         <= (w_state_nxt != StIdle);
    end
  end

  assign burst_active_out        = r_burst;
  assign angle_idx_out           = r_angle;
  assign time_since_emission_out = r_cnt;
  assign listen_out              = r_listen;
  assign echo_time_out           = r_echo_time;
  assign echo_valid_out          = r_echo_valid;
  assign timeout_out             = r_timeout;
  assign angle_result_out        = r_angle_result;
  assign scan_done_out           = r_scan_done;
  assign busy_out                = r_busy;

endmodule
